// File: rtl/mr_witness_check_if.sv
// Handshake/data bundle between the Miller-Rabin witness checker and its producer/consumer.
// The sq_count member exists only when MRW_SQCOUNT_EN is defined.
interface mr_witness_check_if #(
  parameter int BIT_LENGTH = 128,
  parameter int R_WIDTH    = 8
);
  logic                  p_valid;
  logic [BIT_LENGTH-1:0] p_value;
  logic                  x_valid;
  logic [BIT_LENGTH-1:0] x_value;
  logic                  x_ready;
  logic                  result_valid;
  logic                  result_prime;
  logic                  overrun;
  logic [R_WIDTH-1:0]    r_value;
`ifdef MRW_SQCOUNT_EN
  logic [R_WIDTH-1:0]    sq_count;

  modport master (
    output p_valid, p_value, x_valid, x_value,
    input  x_ready, result_valid, result_prime, overrun, r_value, sq_count
  );
  modport slave (
    input  p_valid, p_value, x_valid, x_value,
    output x_ready, result_valid, result_prime, overrun, r_value, sq_count
  );
`else
  modport master (
    output p_valid, p_value, x_valid, x_value,
    input  x_ready, result_valid, result_prime, overrun, r_value
  );
  modport slave (
    input  p_valid, p_value, x_valid, x_value,
    output x_ready, result_valid, result_prime, overrun, r_value
  );
`endif
endinterface

// File: rtl/mr_witness_check.sv
// Miller-Rabin witness checker: derives r from p-1 = m*2^r, then runs the squaring chain on x = a^m mod p.
// Optional MRW_SQCOUNT_EN adds sq_count, the number of squarings spent on the last verdict.
module mr_witness_check #(
  parameter int BIT_LENGTH = 128,
  parameter int R_WIDTH    = 8
) (
  input logic              aclk,
  input logic              aresetn,
  mr_witness_check_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RCOUNT, WAIT_X, CHECK, SQUARE, DONE} state_t;

  state_t                state, state_next;
  logic [BIT_LENGTH-1:0] p, t, x;
  logic [R_WIDTH-1:0]    r, j;
  logic                  p_bad;
  logic                  overrun_q;
  logic                  prime_q;
  logic                  p_load, x_load, x_drop;
  logic                  check_hit, check_prime;
  logic [BIT_LENGTH-1:0] p_minus1;
  logic [R_WIDTH-1:0]    r_minus1;

  // Full-width product reduced in the same cycle; p is never zero here because p_bad exits first.
  function automatic logic [BIT_LENGTH-1:0] sq_mod(input logic [BIT_LENGTH-1:0] a,
                                                   input logic [BIT_LENGTH-1:0] m);
    logic [2*BIT_LENGTH-1:0] prod;
    logic [2*BIT_LENGTH-1:0] modw;
    prod = {{BIT_LENGTH{1'b0}}, a} * {{BIT_LENGTH{1'b0}}, a};
    modw = {{BIT_LENGTH{1'b0}}, m};
    prod = prod % modw;
    return prod[BIT_LENGTH-1:0];
  endfunction

  assign p_minus1 = p - BIT_LENGTH'(1);
  assign r_minus1 = r - R_WIDTH'(1);

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    p_load      = 1'b0;
    x_load      = 1'b0;
    check_hit   = 1'b0;
    check_prime = 1'b0;
    case (state)
      IDLE: begin
        if (bus.p_valid) begin
          p_load     = 1'b1;
          state_next = RCOUNT;
        end
      end
      RCOUNT: begin
        if (p_bad || t[0]) state_next = WAIT_X;
      end
      WAIT_X: begin
        if (bus.p_valid) begin
          p_load     = 1'b1;
          state_next = RCOUNT;
        end else if (bus.x_valid) begin
          x_load     = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (p_bad) begin
          check_hit = 1'b1;
        end else if (j == '0 && x == BIT_LENGTH'(1)) begin
          check_hit   = 1'b1;
          check_prime = 1'b1;
        end else if (x == p_minus1) begin
          check_hit   = 1'b1;
          check_prime = 1'b1;
        end else if (j != '0 && x == BIT_LENGTH'(1)) begin
          check_hit = 1'b1;
        end else if (j == r_minus1) begin
          check_hit = 1'b1;
        end
        state_next = check_hit ? DONE : SQUARE;
      end
      SQUARE:  state_next = CHECK;
      DONE:    state_next = WAIT_X;
      default: state_next = IDLE;
    endcase
  end

  // Any x pulse not consumed by WAIT_X (including one colliding with p_valid) is lost.
  assign x_drop = bus.x_valid && !x_load;

`ifdef MRW_SQCOUNT_EN
  logic [R_WIDTH-1:0] sq_count_q;
  always_ff @(posedge aclk) begin
    if (!aresetn)       sq_count_q <= '0;
    else if (check_hit) sq_count_q <= j;
  end
  assign bus.sq_count = sq_count_q;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      p         <= '0;
      t         <= '0;
      x         <= '0;
      r         <= '0;
      j         <= '0;
      p_bad     <= 1'b0;
      overrun_q <= 1'b0;
      prime_q   <= 1'b0;
    end else begin
      if (x_drop)      overrun_q <= 1'b1;
      else if (p_load) overrun_q <= 1'b0;

      if (p_load) begin
        p     <= bus.p_value;
        t     <= bus.p_value - BIT_LENGTH'(1);
        r     <= '0;
        p_bad <= (bus.p_value < BIT_LENGTH'(3)) || !bus.p_value[0];
      end else if (state == RCOUNT && !p_bad && !t[0]) begin
        t <= t >> 1;
        r <= r + R_WIDTH'(1);
      end

      if (x_load) begin
        x <= bus.x_value;
        j <= '0;
      end else if (state == SQUARE) begin
        x <= sq_mod(x, p);
        j <= j + R_WIDTH'(1);
      end

      if (check_hit) prime_q <= check_prime;
    end
  end

  assign bus.x_ready      = (state == WAIT_X);
  assign bus.result_valid = (state == DONE);
  assign bus.result_prime = prime_q;
  assign bus.overrun      = overrun_q;
  assign bus.r_value      = r;

endmodule

// File: tb/tb_mr_witness_check.sv
// Scoreboard bench for mr_witness_check: directed witnesses with hand-computed verdicts and latencies.
module tb_mr_witness_check;
  localparam int BL = 128;
  localparam int RW = 8;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  mr_witness_check_if #(.BIT_LENGTH(BL), .R_WIDTH(RW)) bus ();

  mr_witness_check #(.BIT_LENGTH(BL), .R_WIDTH(RW)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    int    due;
    logic  prime;
    int    sq;
    int    rv;
    string name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge aclk);
      if (bus.result_valid !== 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected result_valid", 64'(bus.result_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, " latency"}, 64'(cyc), 64'(e.due));
          check({e.name, " prime"}, 64'(bus.result_prime), 64'(e.prime));
          check({e.name, " r_value"}, 64'(bus.r_value), 64'(e.rv));
`ifdef MRW_SQCOUNT_EN
          check({e.name, " sq_count"}, 64'(bus.sq_count), 64'(e.sq));
`endif
        end
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.x_ready !== 1'b1) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check({name, " wait bound"}, 64'(n < 200), 64'd1);
  endtask

  task automatic send_p(input string name, input logic [BL-1:0] val, input int rv);
    @(negedge aclk);
    bus.p_valid = 1'b1;
    bus.p_value = val;
    @(negedge aclk);
    bus.p_valid = 1'b0;
    wait_ready(name);
    check({name, " r_value"}, 64'(bus.r_value), 64'(rv));
  endtask

  task automatic send_x(input string name, input logic [BL-1:0] val, input logic prime,
                        input int sq, input int rv);
    @(negedge aclk);
    bus.x_valid = 1'b1;
    bus.x_value = val;
    sb.push_back('{due: cyc + 2 + 2 * sq, prime: prime, sq: sq, rv: rv, name: name});
    @(negedge aclk);
    bus.x_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " x_ready"}, 64'(bus.x_ready), 64'd0);
    check({name, " result_valid"}, 64'(bus.result_valid), 64'd0);
    check({name, " result_prime"}, 64'(bus.result_prime), 64'd0);
    check({name, " overrun"}, 64'(bus.overrun), 64'd0);
    check({name, " r_value"}, 64'(bus.r_value), 64'd0);
`ifdef MRW_SQCOUNT_EN
    check({name, " sq_count"}, 64'(bus.sq_count), 64'd0);
`endif
  endtask

  initial begin
    bus.p_valid = 1'b0;
    bus.p_value = '0;
    bus.x_valid = 1'b0;
    bus.x_value = '0;
    fork
      monitor();
    join_none

    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check_idle_outputs("reset");
    aresetn = 1'b1;

    // p=13: 12 = 3*2^2
    send_p("p13", BL'(13), 2);
    send_x("p13 x8", BL'(8), 1'b1, 1, 2);
    wait_ready("p13 x8");
    send_x("p13 x1", BL'(1), 1'b1, 0, 2);
    wait_ready("p13 x1");
    send_x("p13 x8 again", BL'(8), 1'b1, 1, 2);
    wait_ready("p13 x8 again");
    send_x("p13 x12", BL'(12), 1'b1, 0, 2);
    wait_ready("p13 x12");

    // p=15: 14 = 7*2^1, chain ends at j==r-1 immediately
    send_p("p15", BL'(15), 1);
    send_x("p15 x8", BL'(8), 1'b0, 0, 1);
    wait_ready("p15 x8");

    // Carmichael 561: 263 -> 166 -> 67 -> 1, stray x pulse during SQUARE
    send_p("p561", BL'(561), 4);
    send_x("p561 x263", BL'(263), 1'b0, 3, 4);
    @(negedge aclk);
    bus.x_valid = 1'b1;
    bus.x_value = BL'(5);
    @(negedge aclk);
    bus.x_valid = 1'b0;
    check("overrun set in SQUARE", 64'(bus.overrun), 64'd1);
    wait_ready("p561 x263");
    check("overrun sticky", 64'(bus.overrun), 64'd1);

    // even and too-small candidates are rejected without squaring
    send_p("p10", BL'(10), 0);
    check("overrun cleared by p", 64'(bus.overrun), 64'd0);
    send_x("p10 x3", BL'(3), 1'b0, 0, 0);
    wait_ready("p10 x3");
    send_p("p1", BL'(1), 0);
    send_x("p1 x1", BL'(1), 1'b0, 0, 0);
    wait_ready("p1 x1");

    // p_valid wins over a simultaneous x_valid in WAIT_X
    @(negedge aclk);
    bus.p_valid = 1'b1;
    bus.p_value = BL'(13);
    bus.x_valid = 1'b1;
    bus.x_value = BL'(8);
    @(negedge aclk);
    bus.p_valid = 1'b0;
    bus.x_valid = 1'b0;
    wait_ready("p13 collide");
    check("collide r_value", 64'(bus.r_value), 64'd2);
    check("collide overrun", 64'(bus.overrun), 64'd1);
    send_x("p13 after collide", BL'(8), 1'b1, 1, 2);
    wait_ready("p13 after collide");

    // reset mid-squaring: no verdict may appear
    send_p("p561 rst", BL'(561), 4);
    @(negedge aclk);
    bus.x_valid = 1'b1;
    bus.x_value = BL'(263);
    @(negedge aclk);
    bus.x_valid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    check_idle_outputs("reset in SQUARE");
    aresetn = 1'b1;
    repeat (12) @(negedge aclk);
    check("idle after reset x_ready", 64'(bus.x_ready), 64'd0);
    check("no pending verdicts", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
